// File: rtl/ulx3s_pkg.sv
// ============================================================================
// Module      : ulx3s_pkg
// Description : Board-level constants shared by the ULX3S button/LED logic.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ulx3s_pkg;

    localparam int unsigned NUM_BTN        = 7;
    localparam int unsigned CLK_HZ         = 25000000;
    localparam logic [NUM_BTN-1:0] BTN_ACTIVE_LOW = 7'b0000001;
    localparam int unsigned DEBOUNCE_10MS  = CLK_HZ / 100;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

`default_nettype wire

// File: rtl/debounce_bit.sv
// ============================================================================
// Module      : debounce_bit
// Description : One button channel: polarity fix, 2-flop sync, stability
//               counter, press/release pulses. Auto-repeat under
//               BTN_DEBOUNCE_REPEAT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module debounce_bit
    import ulx3s_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_10MS,
    parameter logic        ACTIVE_LOW      = 1'b0,
    parameter int unsigned REPEAT_DELAY    = 12500000,
    parameter int unsigned REPEAT_PERIOD   = 2500000
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_btn,
    output logic o_btn,
    output logic o_press,
    output logic o_release
);

    localparam int unsigned      CW     = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]    C_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_q, sync2_q;
    logic          acc_q, acc_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          press_q, press_d;
    logic          release_q, release_d;
    logic          w_accept;

    // Any cycle where the synced level agrees with the accepted one restarts the count.
    always_comb begin
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        w_accept = 1'b0;
        if (sync2_q == acc_q) begin
            cnt_d = '0;
        end else if (cnt_q == C_LAST) begin
            w_accept = 1'b1;
            acc_d    = sync2_q;
            cnt_d    = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    assign release_d = w_accept & ~sync2_q;

`ifdef BTN_DEBOUNCE_REPEAT_EN
    localparam int unsigned   RW            = $clog2(max_u(REPEAT_DELAY, REPEAT_PERIOD));
    localparam logic [RW-1:0] C_DELAY_LAST  = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] C_PERIOD_LAST = RW'(REPEAT_PERIOD - 1);

    logic [RW-1:0] rep_cnt_q, rep_cnt_d;
    logic          rep_arm_q, rep_arm_d;
    logic          w_rep_fire;

    // rep_arm_q selects the initial delay versus the steady repeat period.
    always_comb begin
        rep_cnt_d  = rep_cnt_q;
        rep_arm_d  = rep_arm_q;
        w_rep_fire = 1'b0;
        if (!acc_d || w_accept) begin
            rep_cnt_d = '0;
            rep_arm_d = 1'b0;
        end else if (rep_cnt_q == (rep_arm_q ? C_PERIOD_LAST : C_DELAY_LAST)) begin
            w_rep_fire = 1'b1;
            rep_cnt_d  = '0;
            rep_arm_d  = 1'b1;
        end else begin
            rep_cnt_d = rep_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            rep_cnt_q <= '0;
            rep_arm_q <= 1'b0;
        end else begin
            rep_cnt_q <= rep_cnt_d;
            rep_arm_q <= rep_arm_d;
        end
    end

    assign press_d = (w_accept & sync2_q) | w_rep_fire;
`else
    assign press_d = w_accept & sync2_q;
`endif

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            acc_q     <= 1'b0;
            cnt_q     <= '0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            sync1_q   <= i_btn ^ ACTIVE_LOW;
            sync2_q   <= sync1_q;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    assign o_btn     = acc_q;
    assign o_press   = press_q;
    assign o_release = release_q;

endmodule

`default_nettype wire

// File: rtl/button_debounce.sv
// ============================================================================
// Module      : button_debounce
// Description : N_BTN independent debounce channels for the ULX3S buttons.
//               Optional auto-repeat: define BTN_DEBOUNCE_REPEAT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module button_debounce
    import ulx3s_pkg::*;
#(
    parameter int unsigned         N_BTN           = NUM_BTN,
    parameter int unsigned         DEBOUNCE_CYCLES = DEBOUNCE_10MS,
    parameter logic [N_BTN-1:0]    ACTIVE_LOW_MASK = BTN_ACTIVE_LOW,
    parameter int unsigned         REPEAT_DELAY    = 12500000,
    parameter int unsigned         REPEAT_PERIOD   = 2500000
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic [N_BTN-1:0] i_btn,
    output logic [N_BTN-1:0] o_btn,
    output logic [N_BTN-1:0] o_press,
    output logic [N_BTN-1:0] o_release
);

    generate
        for (genvar g = 0; g < N_BTN; g++) begin : g_chan
            debounce_bit #(
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
                .ACTIVE_LOW      (ACTIVE_LOW_MASK[g]),
                .REPEAT_DELAY    (REPEAT_DELAY),
                .REPEAT_PERIOD   (REPEAT_PERIOD)
            ) u_bit (
                .i_clk     (i_clk),
                .i_reset   (i_reset),
                .i_btn     (i_btn[g]),
                .o_btn     (o_btn[g]),
                .o_press   (o_press[g]),
                .o_release (o_release[g])
            );
        end
    endgenerate

endmodule

`default_nettype wire

// File: tb/tb_button_debounce.sv
// ============================================================================
// Module      : tb_button_debounce
// Description : Scoreboard bench for button_debounce (DEBOUNCE_CYCLES=4).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_button_debounce;

    localparam int unsigned N   = 7;
    localparam int          LAT = 6;  // drive after edge k -> output after edge k+6

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] btn;
    logic [N-1:0] o_btn, o_press, o_release;

    typedef struct {
        int           cyc;
        logic [N-1:0] press;
        logic [N-1:0] rel;
    } ev_t;

    ev_t          sb[$];
    int           cyc = 0;
    int           n_cmp = 0;
    int           n_err = 0;
    bit           chk_en = 1'b0;
    logic [N-1:0] exp_btn = '0;

    button_debounce #(
        .N_BTN           (N),
        .DEBOUNCE_CYCLES (4),
        .ACTIVE_LOW_MASK (7'b0000001),
        .REPEAT_DELAY    (10),
        .REPEAT_PERIOD   (3)
    ) dut (
        .i_clk     (clk),
        .i_reset   (rst),
        .i_btn     (btn),
        .o_btn     (o_btn),
        .o_press   (o_press),
        .o_release (o_release)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got %b expected %b", tag, cyc, got, exp);
        end
    endtask

    task automatic push_ev(input int c, input logic [N-1:0] p, input logic [N-1:0] r);
        ev_t e;
        e.cyc = c; e.press = p; e.rel = r;
        sb.push_back(e);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            logic [N-1:0] ep, er;
            ep = '0;
            er = '0;
            for (int i = sb.size() - 1; i >= 0; i--) begin
                if (sb[i].cyc == cyc) begin
                    ep |= sb[i].press;
                    er |= sb[i].rel;
                    sb.delete(i);
                end
            end
            exp_btn = (exp_btn | ep) & ~er;
            check_eq("press",   o_press,   ep);
            check_eq("release", o_release, er);
            check_eq("level",   o_btn,     exp_btn);
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        btn = 7'b0000001;
        step(1);
        chk_en = 1'b1;
        step(3);
        rst = 1'b0;
        step(8);

        // clean press/release on channel 1
        btn[1] = 1'b1;
        push_ev(cyc + LAT, 7'b0000010, '0);
        step(8);
        btn[1] = 1'b0;
        push_ev(cyc + LAT, '0, 7'b0000010);
        step(10);

        // bounce on channel 2, then hold
        for (int i = 0; i < 5; i++) begin
            btn[2] = (i % 2 == 0);
            if (i < 4) step(1);
        end
        push_ev(cyc + LAT, 7'b0000100, '0);
        step(7);
        btn[2] = 1'b0;
        push_ev(cyc + LAT, '0, 7'b0000100);
        step(10);

        // active-low channel 0
        btn[0] = 1'b0;
        push_ev(cyc + LAT, 7'b0000001, '0);
        step(8);
        btn[0] = 1'b1;
        push_ev(cyc + LAT, '0, 7'b0000001);
        step(10);

        // simultaneous channels 6:3
        btn[6:3] = 4'b1111;
        push_ev(cyc + LAT, 7'b1111000, '0);
        step(8);
        btn[6:3] = 4'b0000;
        push_ev(cyc + LAT, '0, 7'b1111000);
        step(10);

        // reset two cycles into a press, button held through reset
        btn[1] = 1'b1;
        step(2);
        rst = 1'b1;
        step(3);
        rst = 1'b0;
        push_ev(cyc + LAT, 7'b0000010, '0);
        step(8);
        btn[1] = 1'b0;
        push_ev(cyc + LAT, '0, 7'b0000010);
        step(10);

`ifdef BTN_DEBOUNCE_REPEAT_EN
        begin
            int a;
            btn[1] = 1'b1;
            a = cyc + LAT;
            push_ev(a,      7'b0000010, '0);
            push_ev(a + 10, 7'b0000010, '0);
            push_ev(a + 13, 7'b0000010, '0);
            push_ev(a + 16, 7'b0000010, '0);
            step(18);
            btn[1] = 1'b0;
            push_ev(cyc + LAT, '0, 7'b0000010);
            step(15);
        end
`endif

        step(2);
        check_eq("sb_drained", N'(sb.size()), '0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
